// File: rtl/fetch_unit_if.sv
// Instruction memory bus between the fetch stage and a synchronous instruction RAM.
// The RAM returns the word for the address presented on the previous rising edge.
interface fetch_unit_if #(
    parameter int PC_WIDTH = 10
);
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_rd;
    logic [8:0]          imem_rdata;

    modport master (
        output imem_addr,
        output imem_rd,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        input  imem_rd,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage of the tinyarch core.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, waiting for start; memory not read
// RUN   | issuing one address per cycle, registering words to decode
// HALT  | program finished, done=1; start restarts from RESET_PC
//
// Two-deep pipeline: fetch_pc is the next address to issue, resp_pc/resp_valid
// describe the address issued last cycle whose word is on imem_rdata now.
module fetch_unit #(
    parameter int                  PC_WIDTH = 10,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                halt,
    fetch_unit_if.master        imem,
    output logic [8:0]          instr,
    output logic [PC_WIDTH-1:0] instr_pc,
    output logic                instr_valid,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] resp_pc;
    logic                resp_valid;
    logic                hold_read;

    // A plain stall re-issues the in-flight address so the memory output is
    // still the held word when the stall releases; halt/branch override it.
    assign hold_read      = (state == RUN) && stall && !branch_taken && !halt;
    assign imem.imem_rd   = (state == RUN);
    assign imem.imem_addr = hold_read ? resp_pc : fetch_pc;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: halt wins over everything while running.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (halt)  state_nxt = HALT;
            HALT:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Fetch pointer, response tracking and the registered output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= '0;
            resp_valid  <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= (state_nxt == HALT);
            case (state)
                IDLE, HALT: begin
                    instr_valid <= 1'b0;
                    if (start) begin
                        fetch_pc   <= RESET_PC;
                        resp_valid <= 1'b0;
                    end
                end
                RUN: begin
                    if (halt) begin
                        instr_valid <= 1'b0;
                        resp_valid  <= 1'b0;
                    end else if (branch_taken) begin
                        fetch_pc    <= branch_target;
                        resp_valid  <= 1'b0;
                        instr_valid <= 1'b0;
                    end else if (!stall) begin
                        instr       <= imem.imem_rdata;
                        instr_pc    <= resp_pc;
                        instr_valid <= resp_valid;
                        resp_pc     <= fetch_pc;
                        resp_valid  <= 1'b1;
                        fetch_pc    <= fetch_pc + PC_WIDTH'(1);
                    end
                end
                default: begin
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle vector table plus an
// expected-word scoreboard, followed by a hand-written reset-mid-stall sequence.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stall;
    logic       branch_taken;
    logic [9:0] branch_target;
    logic       halt;
    logic [8:0] instr;
    logic [9:0] instr_pc;
    logic       instr_valid;
    logic       done;

    fetch_unit_if #(.PC_WIDTH(10)) bus ();

    fetch_unit #(.PC_WIDTH(10), .RESET_PC(10'd0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt          (halt),
        .imem          (bus),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Synchronous instruction RAM, one-cycle read latency.
    logic [8:0] mem [0:1023];
    always @(posedge clk) begin
        if (bus.imem_rd) bus.imem_rdata <= mem[bus.imem_addr];
    end

    typedef struct {
        bit         start;
        bit         stall;
        bit         br;
        logic [9:0] tgt;
        bit         halt;
        bit         ev;     // expected instr_valid after the edge
        logic [9:0] epc;    // expected instr_pc (valid or held)
        bit         ed;     // expected done
        bit         erd;    // expected imem_rd
        bit         hold;   // check instr_pc even though invalid
    } vec_t;

    typedef struct {
        logic [9:0] pc;
        logic [8:0] w;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [8:0] word_at(input logic [9:0] pc);
        return 9'(pc) + 9'h040;
    endfunction

    task automatic add(input bit s, input bit st, input bit br, input logic [9:0] t,
                       input bit h, input bit ev, input logic [9:0] pc,
                       input bit d, input bit rd, input bit hold);
        vec_t v;
        v.start = s; v.stall = st; v.br = br; v.tgt = t; v.halt = h;
        v.ev = ev; v.epc = pc; v.ed = d; v.erd = rd; v.hold = hold;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_step(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        start         = v.start;
        stall         = v.stall;
        branch_taken  = v.br;
        branch_target = v.tgt;
        halt          = v.halt;
        if (v.ev) begin
            e.pc = v.epc;
            e.w  = word_at(v.epc);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        chk($sformatf("valid@%0d", idx), 32'(instr_valid), 32'(v.ev));
        chk($sformatf("done@%0d", idx), 32'(done), 32'(v.ed));
        chk($sformatf("imem_rd@%0d", idx), 32'(bus.imem_rd), 32'(v.erd));
        if (v.hold) chk($sformatf("held_pc@%0d", idx), 32'(instr_pc), 32'(v.epc));
        if (instr_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty@%0d actual=valid_word expected=no_word", idx);
            end else begin
                e = sb.pop_front();
                chk($sformatf("instr_pc@%0d", idx), 32'(instr_pc), 32'(e.pc));
                chk($sformatf("instr@%0d", idx), 32'(instr), 32'(e.w));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t v;
        for (int i = 0; i < 1024; i++) mem[i] = 9'(i + 'h40);
        bus.imem_rdata = '0;
        rst_n = 1'b0; start = 0; stall = 0; branch_taken = 0; branch_target = '0; halt = 0;

        // straight-line, start ignored in RUN, stall for 3 cycles
        add(1,0,0,10'h000,0, 0,10'd0,0,1,0);
        add(0,0,0,10'h000,0, 0,10'd0,0,1,0);
        add(0,0,0,10'h000,0, 1,10'd0,0,1,0);
        add(1,0,0,10'h000,0, 1,10'd1,0,1,0);
        add(0,0,0,10'h000,0, 1,10'd2,0,1,0);
        for (int i = 0; i < 3; i++) add(0,1,0,10'h000,0, 1,10'd2,0,1,0);
        add(0,0,0,10'h000,0, 1,10'd3,0,1,0);
        add(0,0,0,10'h000,0, 1,10'd4,0,1,0);
        add(0,0,0,10'h000,0, 1,10'd5,0,1,0);
        // branch with stall in the same cycle
        add(0,1,1,10'h100,0, 0,10'd0,0,1,0);
        add(0,0,0,10'h000,0, 0,10'd0,0,1,0);
        add(0,0,0,10'h000,0, 1,10'h100,0,1,0);
        add(0,0,0,10'h000,0, 1,10'h101,0,1,0);
        // branch near the top of the address space, then wrap
        add(0,0,1,10'h3FE,0, 0,10'd0,0,1,0);
        add(0,0,0,10'h000,0, 0,10'd0,0,1,0);
        add(0,0,0,10'h000,0, 1,10'h3FE,0,1,0);
        add(0,0,0,10'h000,0, 1,10'h3FF,0,1,0);
        for (int i = 0; i < 8; i++) add(0,0,0,10'h000,0, 1,10'(i),0,1,0);
        // halt at pc 7, stall ignored in HALT, restart
        add(0,0,0,10'h000,1, 0,10'd7,1,0,1);
        add(0,1,0,10'h000,0, 0,10'd7,1,0,1);
        add(1,0,0,10'h000,0, 0,10'd0,0,1,0);
        add(0,0,0,10'h000,0, 0,10'd0,0,1,0);
        add(0,0,0,10'h000,0, 1,10'd0,0,1,0);
        add(0,0,0,10'h000,0, 1,10'd1,0,1,0);
        // halt + branch together -> HALT; branch outside RUN ignored
        add(0,0,1,10'h050,1, 0,10'd1,1,0,1);
        add(0,0,1,10'h020,0, 0,10'd1,1,0,1);
        add(1,0,0,10'h000,0, 0,10'd0,0,1,0);
        add(0,0,0,10'h000,0, 0,10'd0,0,1,0);
        add(0,0,0,10'h000,0, 1,10'd0,0,1,0);
        add(0,0,0,10'h000,0, 1,10'd1,0,1,0);
        add(0,1,0,10'h000,0, 1,10'd1,0,1,0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd", 32'(bus.imem_rd), 32'd0);
        chk("rst_addr", 32'(bus.imem_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) do_step(tbl[i], i);

        // reset asserted mid-stall takes effect without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_instr", 32'(instr), 32'd0);
        chk("mid_rst_pc", 32'(instr_pc), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_rd", 32'(bus.imem_rd), 32'd0);
        chk("mid_rst_addr", 32'(bus.imem_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // stall in IDLE is ignored, then start restarts from address 0
        v = '{start:0, stall:1, br:0, tgt:10'h0, halt:0, ev:0, epc:10'h0, ed:0, erd:0, hold:1};
        do_step(v, 100);
        v = '{start:1, stall:0, br:0, tgt:10'h0, halt:0, ev:0, epc:10'h0, ed:0, erd:1, hold:0};
        do_step(v, 101);
        v.start = 0;
        do_step(v, 102);
        v.ev = 1; v.epc = 10'd0;
        do_step(v, 103);
        v.epc = 10'd1;
        do_step(v, 104);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
